// File: rtl/adc_scan_scheduler.sv
`timescale 1ns / 1ps
// adc_scan_scheduler
//   Scan sequencer for the 8-channel 10-bit SPI ADC on the Pmod_ADC board.
//   Runs periodic (enable) or triggered (trig) scans over a latched channel
//   mask. For each set bit it runs one SPI frame: it drives AD_CLK/CS/DIN,
//   shifts in DOUT and presents the result on a one-entry valid/ready output.
//
// Ports
//   clk, rst_n            system clock, async active-low reset
//   enable                arms the periodic scan timer
//   trig                  one-cycle scan request (ORed with the periodic tick)
//   ch_mask[7:0]          channels to convert, latched at scan start
//   single_ended          SGL/DIFF command bit, latched at scan start
//   AD_CLK, CS, DIN       SPI master outputs (AD_CLK idles low, CS active low)
//   DOUT                  SPI data from the ADC, asynchronous to clk
//   sample_valid/ready    output handshake
//   sample_ch, sample_data  channel and B9..B0 of the held sample
//   busy                  scan in progress
//   overrun               sticky: a finished sample found the output full
//   scan_late             sticky: a request arrived while one was pending
//
// State    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | no scan; a request or pending request launches one
// S_SETUP  | CS low, AD_CLK low, DIN = start bit, one half-period
// S_SHIFT  | 17 AD_CLK periods (34 half-periods, low phase first)
// S_CSHOLD | CS high between frames, all but the last cycle of the gap
// S_NEXT   | last gap cycle: next channel, back-to-back scan, or idle
module adc_scan_scheduler #(
    parameter int CLK_DIV     = 38,
    parameter int CS_HIGH     = 2,
    parameter int SCAN_PERIOD = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       trig,
    input  logic [7:0] ch_mask,
    input  logic       single_ended,
    output logic       AD_CLK,
    output logic       CS,
    output logic       DIN,
    input  logic       DOUT,
    output logic       sample_valid,
    input  logic       sample_ready,
    output logic [2:0] sample_ch,
    output logic [9:0] sample_data,
    output logic       busy,
    output logic       overrun,
    output logic       scan_late
);

    localparam int HOLD_CYC = CS_HIGH * CLK_DIV;
    localparam int TMR_W    = $clog2(HOLD_CYC) + 1;
    localparam int PER_W    = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

    localparam logic [TMR_W-1:0] HALF_LD  = TMR_W'(CLK_DIV - 1);
    // The final gap cycle is spent in S_NEXT, so CSHOLD runs one cycle short.
    localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(HOLD_CYC - 2);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SCAN_PERIOD - 1);
    localparam logic [5:0]       LAST_HP  = 6'd33;
    localparam logic [5:0]       FIRST_DATA_HP = 6'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_CSHOLD,
        S_NEXT
    } state_t;

    state_t           state, state_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic [5:0]       hp_idx, hp_nxt;

    logic [PER_W-1:0] per_cnt;
    logic             tick, req, pending, en_q, en_fall;
    logic [7:0]       rem_mask, rem_after;
    logic [2:0]       cur_ch;
    logic             sgl_q;
    logic             dout_s1, dout_s2;
    logic [8:0]       shreg;

    logic tmr_tc, can_launch, launch, launch_go;
    logic capture, load_evt, take;
    logic cs_nxt, ad_clk_nxt, din_nxt, busy_nxt;

    assign tick    = enable && (per_cnt == PER_LAST);
    assign req     = tick || trig;
    assign en_fall = en_q && !enable;
    assign tmr_tc  = (tmr == '0);

    // Lowest remaining channel is the one being converted.
    always_comb begin
        cur_ch = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rem_mask[i]) cur_ch = 3'(i);
        end
    end

    assign rem_after = rem_mask & ~(8'd1 << cur_ch);

    // A new scan may start from IDLE, or directly out of the last frame's gap
    // so that a pending request runs back-to-back with no extra idle cycle.
    assign can_launch = (state == S_IDLE) ||
                        ((state == S_NEXT) && (rem_after == 8'd0));
    assign launch     = can_launch && (req || pending);
    assign launch_go  = launch && (ch_mask != 8'd0);

    // DOUT is sampled on the cycle that ends a high phase; only edges 8..17
    // carry result bits.
    assign capture  = (state == S_SHIFT) && hp_idx[0] && tmr_tc;
    assign load_evt = capture && (hp_idx == LAST_HP);
    assign take     = load_evt && (!sample_valid || sample_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            tmr    <= '0;
            hp_idx <= '0;
        end else begin
            state  <= state_nxt;
            tmr    <= tmr_nxt;
            hp_idx <= hp_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        hp_nxt    = hp_idx;
        case (state)
            S_IDLE: begin
                if (launch_go) begin
                    state_nxt = S_SETUP;
                    tmr_nxt   = HALF_LD;
                end
            end
            S_SETUP: begin
                if (tmr_tc) begin
                    state_nxt = S_SHIFT;
                    tmr_nxt   = HALF_LD;
                    hp_nxt    = 6'd0;
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            S_SHIFT: begin
                if (tmr_tc) begin
                    if (hp_idx == LAST_HP) begin
                        state_nxt = S_CSHOLD;
                        tmr_nxt   = HOLD_LD;
                    end else begin
                        hp_nxt  = hp_idx + 6'd1;
                        tmr_nxt = HALF_LD;
                    end
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            S_CSHOLD: begin
                if (tmr_tc) begin
                    state_nxt = S_NEXT;
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            S_NEXT: begin
                if (rem_after != 8'd0 || launch_go) begin
                    state_nxt = S_SETUP;
                    tmr_nxt   = HALF_LD;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Pin values follow the next state so they change on the same edge.
        // DIN depends on hp>>1, so it only moves when AD_CLK goes low.
        cs_nxt     = !((state_nxt == S_SETUP) || (state_nxt == S_SHIFT));
        ad_clk_nxt = (state_nxt == S_SHIFT) && hp_nxt[0];
        busy_nxt   = (state_nxt != S_IDLE);
        din_nxt    = 1'b0;
        if (state_nxt == S_SETUP) begin
            din_nxt = 1'b1;
        end else if (state_nxt == S_SHIFT) begin
            case (hp_nxt[5:1])
                5'd0:    din_nxt = 1'b1;
                5'd1:    din_nxt = sgl_q;
                5'd2:    din_nxt = cur_ch[2];
                5'd3:    din_nxt = cur_ch[1];
                5'd4:    din_nxt = cur_ch[0];
                default: din_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            CS      <= 1'b1;
            AD_CLK  <= 1'b0;
            DIN     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            CS      <= cs_nxt;
            AD_CLK  <= ad_clk_nxt;
            DIN     <= din_nxt;
            busy    <= busy_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt <= '0;
            en_q    <= 1'b0;
        end else begin
            en_q <= enable;
            if (!enable || tick) begin
                per_cnt <= '0;
            end else begin
                per_cnt <= per_cnt + PER_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= 1'b0;
            scan_late <= 1'b0;
            overrun   <= 1'b0;
            rem_mask  <= 8'd0;
            sgl_q     <= 1'b0;
        end else begin
            // trig during enable is still honoured when enable falls on the
            // same cycle; only the stale pending request is dropped.
            if (launch) begin
                pending <= 1'b0;
            end else if (state != S_IDLE && req) begin
                pending <= 1'b1;
            end else if (en_fall) begin
                pending <= 1'b0;
            end

            if (trig && !enable) begin
                scan_late <= 1'b0;
                overrun   <= 1'b0;
            end else begin
                if (req && pending) scan_late <= 1'b1;
                if (load_evt && !take) overrun <= 1'b1;
            end

            if (launch_go) begin
                rem_mask <= ch_mask;
                sgl_q    <= single_ended;
            end else if (state == S_NEXT) begin
                rem_mask <= rem_after;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_s1 <= 1'b0;
            dout_s2 <= 1'b0;
            shreg   <= 9'd0;
        end else begin
            dout_s1 <= DOUT;
            dout_s2 <= dout_s1;
            if (capture && hp_idx >= FIRST_DATA_HP) begin
                shreg <= {shreg[7:0], dout_s2};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_valid <= 1'b0;
            sample_ch    <= 3'd0;
            sample_data  <= 10'd0;
        end else begin
            if (take) begin
                sample_valid <= 1'b1;
                sample_ch    <= cur_ch;
                sample_data  <= {shreg, dout_s2};
            end else if (sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_scan_scheduler.sv
`timescale 1ns / 1ps
module tb_adc_scan_scheduler;

    localparam int CLK_DIV     = 4;
    localparam int CS_HIGH     = 2;
    localparam int SCAN_PERIOD = 200;
    localparam int CLK_PER     = 10;
    localparam int CS_LOW_CYC  = CLK_DIV * 35;
    localparam int FRAME_CYC   = CLK_DIV * (1 + 34 + CS_HIGH);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       trig = 1'b0;
    logic [7:0] ch_mask = 8'd0;
    logic       single_ended = 1'b0;
    logic       DOUT = 1'b0;
    logic       sample_ready = 1'b0;
    logic       AD_CLK, CS, DIN, sample_valid, busy, overrun, scan_late;
    logic [2:0] sample_ch;
    logic [9:0] sample_data;

    adc_scan_scheduler #(
        .CLK_DIV     (CLK_DIV),
        .CS_HIGH     (CS_HIGH),
        .SCAN_PERIOD (SCAN_PERIOD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .trig         (trig),
        .ch_mask      (ch_mask),
        .single_ended (single_ended),
        .AD_CLK       (AD_CLK),
        .CS           (CS),
        .DIN          (DIN),
        .DOUT         (DOUT),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_ch    (sample_ch),
        .sample_data  (sample_data),
        .busy         (busy),
        .overrun      (overrun),
        .scan_late    (scan_late)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ADC model and scoreboards
    logic [9:0]  chan_val [8];
    logic [3:0]  exp_cmd_q [$];   // {sgl, ch} expected per frame, in order
    logic [12:0] exp_q [$];       // {ch, data} expected at the output
    logic [3:0]  cmd_e;
    logic [12:0] sb_e, head;
    logic [4:0]  cmd = 5'd0;
    logic [9:0]  cur_data = 10'd0;
    int          rises = 0;
    int          n_frames = 0;
    int          n_busy_fall = 0;
    logic        frame_active = 1'b0;
    logic        din_tail = 1'b0;
    logic        skip_frame_chk = 1'b0;
    logic        b2b_mode = 1'b0;
    logic        have_prev = 1'b0;
    time         t_fall = 0;
    time         t_busy_fall = 0;

    always @(negedge CS) begin
        if (b2b_mode && have_prev)
            check_val("frame_period", 32'(($time - t_fall) / CLK_PER), FRAME_CYC);
        have_prev    = b2b_mode;
        t_fall       = $time;
        rises        = 0;
        cmd          = 5'd0;
        din_tail     = 1'b0;
        frame_active = 1'b1;
    end

    always @(posedge CS) begin
        if (frame_active && !skip_frame_chk) begin
            check_val("ad_clk_rises", rises, 17);
            check_val("cs_low_len", 32'(($time - t_fall) / CLK_PER), CS_LOW_CYC);
            check_val("din_tail_zero", din_tail, 0);
            n_frames++;
        end
        frame_active = 1'b0;
    end

    always @(posedge AD_CLK) begin
        rises++;
        if (rises <= 5) cmd = {cmd[3:0], DIN};
        else if (DIN) din_tail = 1'b1;
        if (rises == 5) begin
            cur_data = chan_val[cmd[2:0]];
            if (exp_cmd_q.size() == 0) begin
                check_val("cmd_unexpected", {27'd0, cmd}, 0);
            end else begin
                cmd_e = exp_cmd_q.pop_front();
                check_val("cmd_bits", {27'd0, cmd}, {27'd0, 1'b1, cmd_e});
                exp_q.push_back({cmd_e[2:0], chan_val[cmd_e[2:0]]});
            end
        end
    end

    // Result bits appear after the falling edge that follows the null bit.
    always @(negedge AD_CLK) begin
        if (rises >= 7 && rises <= 16) DOUT = cur_data[16 - rises];
        else DOUT = 1'($urandom_range(0, 1));
    end

    always @(negedge busy) begin
        t_busy_fall = $time;
        n_busy_fall++;
    end

    always @(negedge clk) begin
        if (rst_n && sample_valid && sample_ready) begin
            if (exp_q.size() == 0) begin
                check_val("sb_empty", sample_valid, 0);
            end else begin
                sb_e = exp_q.pop_front();
                check_val("sample_ch", 32'(sample_ch), 32'(sb_e[12:10]));
                check_val("sample_data", 32'(sample_data), 32'(sb_e[9:0]));
            end
        end
    end

    task automatic pulse_trig();
        @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic wait_busy_low(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_busy_done"}, busy, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_sticky(input string tag);
        logic saw = 1'b0;
        enable  = 1'b0;
        ch_mask = 8'd0;
        pulse_trig();
        if (busy || !CS) saw = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (busy || !CS) saw = 1'b1;
        end
        check_val({tag, "_mask0_idle"}, saw, 0);
        check_val({tag, "_overrun_clr"}, overrun, 0);
        check_val({tag, "_late_clr"}, scan_late, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, bf0, n;
        logic saw;
        chan_val[0] = 10'h2A5; chan_val[1] = 10'h155;
        chan_val[2] = 10'h3C3; chan_val[3] = 10'h0F0;
        chan_val[4] = 10'h3FF; chan_val[5] = 10'h001;
        chan_val[6] = 10'h200; chan_val[7] = 10'h16B;

        // reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_cs", CS, 1);
        check_val("rst_adclk", AD_CLK, 0);
        check_val("rst_din", DIN, 0);
        check_val("rst_valid", sample_valid, 0);
        check_val("rst_ch", 32'(sample_ch), 0);
        check_val("rst_data", 32'(sample_data), 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_overrun", overrun, 0);
        check_val("rst_late", scan_late, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single channel 0, SGL=1
        ch_mask = 8'h01; single_ended = 1'b1; sample_ready = 1'b1;
        exp_cmd_q.push_back({1'b1, 3'd0});
        f0 = n_frames;
        pulse_trig();
        check_val("t1_busy_rise", busy, 1);
        check_val("t1_cs_fall", CS, 0);
        wait_busy_low("t1", 400);
        check_val("t1_frame_len", 32'((t_busy_fall - t_fall) / CLK_PER), FRAME_CYC);
        check_val("t1_frames", n_frames - f0, 1);
        check_val("t1_sb_drained", exp_q.size(), 0);

        // sparse mask: channels 2, 5, 7 in order, SGL=0
        ch_mask = 8'b1010_0100; single_ended = 1'b0;
        exp_cmd_q.push_back({1'b0, 3'd2});
        exp_cmd_q.push_back({1'b0, 3'd5});
        exp_cmd_q.push_back({1'b0, 3'd7});
        f0 = n_frames;
        pulse_trig();
        wait_busy_low("t2", 600);
        check_val("t2_frames", n_frames - f0, 3);
        check_val("t2_sb_drained", exp_q.size(), 0);

        // output held while not ready; second sample dropped
        sample_ready = 1'b0; ch_mask = 8'h03; single_ended = 1'b1;
        exp_cmd_q.push_back({1'b1, 3'd0});
        exp_cmd_q.push_back({1'b1, 3'd1});
        pulse_trig();
        wait_busy_low("t3", 500);
        check_val("t3_overrun", overrun, 1);
        check_val("t3_valid_held", sample_valid, 1);
        check_val("t3_sb_count", exp_q.size(), 2);
        head = exp_q[0];
        check_val("t3_held_ch", 32'(sample_ch), 32'(head[12:10]));
        check_val("t3_held_data", 32'(sample_data), 32'(head[9:0]));
        void'(exp_q.pop_back());
        sample_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_val("t3_valid_drop", sample_valid, 0);
        check_val("t3_sb_drained", exp_q.size(), 0);
        check_val("t3_overrun_sticky", overrun, 1);

        clear_sticky("t5a");

        // periodic scanning, full mask, scans longer than the period
        ch_mask = 8'hFF; single_ended = 1'b1;
        for (int i = 0; i < 16; i++) exp_cmd_q.push_back({1'b1, 3'(i % 8)});
        f0 = n_frames; bf0 = n_busy_fall;
        b2b_mode = 1'b1; have_prev = 1'b0;
        enable = 1'b1;
        n = 0;
        while (!busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_val("t4_busy_rise", busy, 1);
        n = 0;
        while ((n_frames - f0) < 10 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_val("t4_ten_frames", (n_frames - f0) >= 10, 1);
        enable = 1'b0;
        wait_busy_low("t4", 1500);
        b2b_mode = 1'b0;
        check_val("t4_frames", n_frames - f0, 16);
        check_val("t4_busy_falls", n_busy_fall - bf0, 1);
        check_val("t4_scan_late", scan_late, 1);
        check_val("t4_cmd_drained", exp_cmd_q.size(), 0);
        check_val("t4_sb_drained", exp_q.size(), 0);

        clear_sticky("t5b");

        // reset during SHIFT rising edge 10
        ch_mask = 8'h01; single_ended = 1'b1;
        exp_cmd_q.push_back({1'b1, 3'd0});
        pulse_trig();
        n = 0;
        while (rises < 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("t6_reached_edge10", rises, 10);
        skip_frame_chk = 1'b1;
        rst_n = 1'b0;
        #1;
        check_val("t6_cs_async", CS, 1);
        check_val("t6_adclk_async", AD_CLK, 0);
        check_val("t6_busy_async", busy, 0);
        exp_q.delete();
        saw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (sample_valid) saw = 1'b1;
        end
        rst_n = 1'b1;
        skip_frame_chk = 1'b0;
        repeat (160) begin
            @(negedge clk);
            if (sample_valid) saw = 1'b1;
        end
        check_val("t6_no_partial", saw, 0);
        exp_cmd_q.push_back({1'b1, 3'd0});
        f0 = n_frames;
        pulse_trig();
        wait_busy_low("t6", 400);
        check_val("t6_frames", n_frames - f0, 1);
        check_val("t6_sb_drained", exp_q.size(), 0);
        check_val("end_cmd_drained", exp_cmd_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
